mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single linear-memory port (1-cycle read latency, same timing as the existing line memory) between two requesters.
- Requester 0 is the CPU core's load/store path. Requester 1 is the host port, which preloads data or program images and reads back results.
- Core has priority. The host is guaranteed service through a starvation counter, and can lock the port for atomic bursts.
- Sits between the control unit/ALU address path and the memory instance.

Parameters:
ADDR_W, 32, address width on all ports
DATA_W, 32, data width on all ports
STARVE_LIMIT, 4, consecutive cycles the host may be refused before it is forced in (1..255)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
core_req_vld  in  1  core request valid
core_we  in  1  1=store, 0=load
core_addr  in  ADDR_W  core address
core_wdata  in  DATA_W  core store data
core_req_rdy  out  1  core request accepted this cycle
core_rd_data  out  DATA_W  load data to core
core_rd_vld  out  1  core load data valid
host_req_vld  in  1  host request valid
host_we  in  1  1=write, 0=read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_lock  in  1  keep grant after current host grant
host_req_rdy  out  1  host request accepted this cycle
host_rd_data  out  DATA_W  read data to host
host_rd_vld  out  1  host read data valid
mem_re  out  1  memory read enable
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wr_data  out  DATA_W  memory write data
mem_rd_data  in  DATA_W  memory read data, valid 1 cycle after mem_re

Behaviour:
- Interface (already decided): one clock, i_clk; reset i_rst is asynchronous and active-high.
- Reset values: state=IDLE, starve_cnt=0, rd_owner=0, rd_pend=0. This forces core_rd_vld=host_rd_vld=0. mem_re=mem_we=0 while i_rst is high.
- State machine:
  - States: IDLE, HOST_LOCK.
  - IDLE -> HOST_LOCK: on a host grant with host_lock=1.
  - HOST_LOCK -> IDLE: on the first cycle host_lock=0, whether or not a host request is present.
- Grant rules (combinational, same cycle):
  - In HOST_LOCK: grant_host = host_req_vld; core is never granted.
  - In IDLE: grant_host = host_req_vld & (~core_req_vld | starve_cnt==STARVE_LIMIT); grant_core = core_req_vld & ~grant_host.
  - core_req_rdy=grant_core and host_req_rdy=grant_host. At most one is high per cycle.
- Memory command: combinational mux of the granted requester's we/addr/wdata.
  - mem_re = grant & ~we; mem_we = grant & we.
  - With no grant, mem_re=mem_we=0, and addr/wdata are driven from core.
- starve_cnt:
  - +1 each cycle host_req_vld=1 and the host is not granted; saturates at STARVE_LIMIT.
  - Cleared on host grant, and whenever host_req_vld=0.
- Read return:
  - On a read grant: rd_pend<=1, rd_owner<=requester; otherwise rd_pend<=0.
  - Next cycle: the owner's rd_vld=1 and rd_data=mem_rd_data. The other requester's rd_vld=0.
  - rd_data outputs mirror mem_rd_data unconditionally; consumers qualify with rd_vld.
- Throughput: back-to-back reads are allowed (one grant per cycle); read latency is exactly 1 cycle.
- Writes produce no response.
- A requester must hold its vld and payload stable until it sees rdy.
- Reset asserted mid-read: the pending rd_vld is dropped and the lock is released.

Optional Feature:
- Macro: MEM_ARB_STATS_EN.
- With it defined: the block adds outputs core_grant_cnt[31:0], host_grant_cnt[31:0] and forced_grant_cnt[31:0].
  - Each counts its grants; forced grants are host grants won via starve_cnt==STARVE_LIMIT.
  - Counters wrap at 2^32 and reset to 0.
- Without it: these ports and registers do not exist, and behaviour is otherwise identical.

Test Plan:
- Core read alone, core_addr=0x10 -> core_req_rdy=1 the same cycle; next cycle core_rd_vld=1, core_rd_data=mem[0x10]; host_rd_vld=0.
- Core and host both request continuously, STARVE_LIMIT=4 -> core granted 4 cycles, host granted on the 5th, then core again (pattern C,C,C,C,H repeating).
- Host write 0xDEADBEEF to 0x20 with host_lock=1 for 3 writes while core requests -> core_req_rdy=0 for those 3 cycles. Lock released when host_lock=0; core granted that cycle.
- Alternating core read 0x4 / host read 0x8 on consecutive cycles -> rd_vld reaches the correct owner with data mem[0x4] then mem[0x8], with no cross-delivery.
- Assert i_rst while host read pending and state=HOST_LOCK -> host_rd_vld=0 immediately, state IDLE, starve_cnt=0, mem_we=mem_re=0.
- With MEM_ARB_STATS_EN, 10 core grants and 3 host grants (2 forced) -> core_grant_cnt=10, host_grant_cnt=3, forced_grant_cnt=2.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single linear-memory port (core priority, host starvation guard, host lock).
// Optional grant statistics outputs are compiled in with `define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              core_req_vld,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_req_rdy,
    output logic [DATA_W-1:0] core_rd_data,
    output logic              core_rd_vld,
    input  logic              host_req_vld,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              host_lock,
    output logic              host_req_rdy,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              host_rd_vld,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]       core_grant_cnt,
    output logic [31:0]       host_grant_cnt,
    output logic [31:0]       forced_grant_cnt,
`endif
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    typedef enum logic {IDLE, HOST_LOCK} state_t;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    state_t     state_reg, state_next;
    logic [7:0] starve_cnt_reg, starve_cnt_next;
    logic       rd_pend_reg, rd_owner_reg;
    logic       locked, starved, grant_host, grant_core, grant_any, sel_we;

    // The lock only holds while host_lock stays high; the cycle it drops already
    // arbitrates with normal priority, so a waiting core is served immediately.
    always_comb begin
        locked     = (state_reg == HOST_LOCK) && host_lock;
        starved    = (starve_cnt_reg == LIMIT);
        grant_host = 1'b0;
        grant_core = 1'b0;
        if (!i_rst) begin
            if (locked) begin
                grant_host = host_req_vld;
            end else begin
                grant_host = host_req_vld && (!core_req_vld || starved);
                grant_core = core_req_vld && !grant_host;
            end
        end
        grant_any = grant_host || grant_core;
    end

    assign core_req_rdy = grant_core;
    assign host_req_rdy = grant_host;

    always_comb begin
        sel_we      = grant_host ? host_we    : core_we;
        mem_addr    = grant_host ? host_addr  : core_addr;
        mem_wr_data = grant_host ? host_wdata : core_wdata;
        mem_re      = grant_any && !sel_we;
        mem_we      = grant_any && sel_we;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (grant_host && host_lock) state_next = HOST_LOCK;
            HOST_LOCK: if (!host_lock)              state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (!host_req_vld || grant_host)
            starve_cnt_next = 8'd0;
        else if (starve_cnt_reg != LIMIT)
            starve_cnt_next = starve_cnt_reg + 8'd1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 8'd0;
            rd_pend_reg    <= 1'b0;
            rd_owner_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            rd_pend_reg    <= mem_re;
            if (mem_re)
                rd_owner_reg <= grant_host;
        end
    end

    assign core_rd_vld  = rd_pend_reg && !rd_owner_reg;
    assign host_rd_vld  = rd_pend_reg && rd_owner_reg;
    assign core_rd_data = mem_rd_data;
    assign host_rd_data = mem_rd_data;

`ifdef MEM_ARB_STATS_EN
    logic forced_grant;
    assign forced_grant = grant_host && !locked && core_req_vld && starved;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            core_grant_cnt   <= 32'd0;
            host_grant_cnt   <= 32'd0;
            forced_grant_cnt <= 32'd0;
        end else begin
            if (grant_core)   core_grant_cnt   <= core_grant_cnt + 32'd1;
            if (grant_host)   host_grant_cnt   <= host_grant_cnt + 32'd1;
            if (forced_grant) forced_grant_cnt <= forced_grant_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a 1-cycle-latency memory model.
// Statistics checks run only when MEM_ARB_STATS_EN is defined.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_req_vld = 1'b0, core_we = 1'b0;
    logic [31:0] core_addr = '0, core_wdata = '0;
    logic        core_req_rdy, core_rd_vld;
    logic [31:0] core_rd_data;
    logic        host_req_vld = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [31:0] host_addr = '0, host_wdata = '0;
    logic        host_req_rdy, host_rd_vld;
    logic [31:0] host_rd_data;
    logic        mem_re, mem_we;
    logic [31:0] mem_addr, mem_wr_data;
    logic [31:0] mem_rd_data = '0;
`ifdef MEM_ARB_STATS_EN
    logic [31:0] core_grant_cnt, host_grant_cnt, forced_grant_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] tb_mem [0:255];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .core_req_vld(core_req_vld), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_req_rdy(core_req_rdy),
        .core_rd_data(core_rd_data), .core_rd_vld(core_rd_vld),
        .host_req_vld(host_req_vld), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_lock(host_lock), .host_req_rdy(host_req_rdy),
        .host_rd_data(host_rd_data), .host_rd_vld(host_rd_vld),
`ifdef MEM_ARB_STATS_EN
        .core_grant_cnt(core_grant_cnt), .host_grant_cnt(host_grant_cnt),
        .forced_grant_cnt(forced_grant_cnt),
`endif
        .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
    );

    // Memory model: preloaded with 0xA000_0000 | index while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 32'hA000_0000 | i;
        end else begin
            if (mem_we) tb_mem[mem_addr[7:0]] <= mem_wr_data;
            if (mem_re) mem_rd_data <= tb_mem[mem_addr[7:0]];
        end
    end

    task automatic set_core(input logic vld, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        core_req_vld = vld; core_we = we; core_addr = addr; core_wdata = wdata;
    endtask

    task automatic set_host(input logic vld, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic lock);
        host_req_vld = vld; host_we = we; host_addr = addr; host_wdata = wdata; host_lock = lock;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        set_host(1'b1, 1'b1, 32'h20, 32'h1234, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        $display("txn reset: held with both requesters active");
        checks++; if (mem_re !== 1'b0) begin errors++; $display("FAIL reset_mem_re: got %b expected 0", mem_re); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (core_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_core_rd_vld: got %b expected 0", core_rd_vld); end
        checks++; if (host_rd_vld !== 1'b0) begin errors++; $display("FAIL reset_host_rd_vld: got %b expected 0", host_rd_vld); end
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_core_read();
        @(negedge clk);
        set_core(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        $display("txn core_read: addr=0x10");
        checks++; if (core_req_rdy !== 1'b1) begin errors++; $display("FAIL core_read_rdy: got %b expected 1", core_req_rdy); end
        checks++; if (mem_re !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("FAIL core_read_cmd: got re=%b addr=%h expected re=1 addr=00000010", mem_re, mem_addr); end
        @(posedge clk); #1;
        checks++; if (core_rd_vld !== 1'b1) begin errors++; $display("FAIL core_read_vld: got %b expected 1", core_rd_vld); end
        checks++; if (core_rd_data !== 32'hA000_0010) begin errors++; $display("FAIL core_read_data: got %h expected a0000010", core_rd_data); end
        checks++; if (host_rd_vld !== 1'b0) begin errors++; $display("FAIL core_read_host_vld: got %b expected 0", host_rd_vld); end
        @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        checks++; if (core_rd_vld !== 1'b0) begin errors++; $display("FAIL core_read_vld_drop: got %b expected 0", core_rd_vld); end
    endtask

    // Both requesters read continuously; bit i of host_turn marks cycle i as a host grant.
    task automatic test_starvation();
        logic [9:0] host_turn;
        host_turn = 10'b10_0001_0000;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            set_core(1'b1, 1'b0, 32'h1, 32'h0);
            set_host(1'b1, 1'b0, 32'h2, 32'h0, 1'b0);
            #1;
            $display("txn starve cycle %0d: core_rdy=%b host_rdy=%b", c, core_req_rdy, host_req_rdy);
            checks++; if (host_req_rdy !== host_turn[c] || core_req_rdy !== !host_turn[c]) begin
                errors++; $display("FAIL starve_grant c%0d: got core=%b host=%b expected core=%b host=%b",
                                   c, core_req_rdy, host_req_rdy, !host_turn[c], host_turn[c]);
            end
            @(posedge clk); #1;
            checks++; if (host_rd_vld !== host_turn[c] || core_rd_vld !== !host_turn[c] ||
                          core_rd_data !== (host_turn[c] ? 32'hA000_0002 : 32'hA000_0001)) begin
                errors++; $display("FAIL starve_return c%0d: got core_vld=%b host_vld=%b data=%h", c, core_rd_vld, host_rd_vld, core_rd_data);
            end
        end
        @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_host_lock();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            set_core(c != 0, 1'b0, 32'h20, 32'h0);
            set_host(1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 1'b1);
            #1;
            $display("txn lock write %0d: host_rdy=%b core_rdy=%b", c, host_req_rdy, core_req_rdy);
            checks++; if (host_req_rdy !== 1'b1 || core_req_rdy !== 1'b0) begin
                errors++; $display("FAIL lock_grant w%0d: got host=%b core=%b expected host=1 core=0", c, host_req_rdy, core_req_rdy);
            end
            checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 32'h20 || mem_wr_data !== 32'hDEAD_BEEF) begin
                errors++; $display("FAIL lock_cmd w%0d: got we=%b re=%b addr=%h data=%h", c, mem_we, mem_re, mem_addr, mem_wr_data);
            end
        end
        @(negedge clk);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        $display("txn lock release: core read 0x20");
        checks++; if (core_req_rdy !== 1'b1) begin errors++; $display("FAIL lock_release_core: got %b expected 1", core_req_rdy); end
        @(posedge clk); #1;
        checks++; if (core_rd_vld !== 1'b1 || core_rd_data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL lock_readback: got vld=%b data=%h expected vld=1 data=deadbeef", core_rd_vld, core_rd_data);
        end
        @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_alternate();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c % 2 == 0) begin
                set_core(1'b1, 1'b0, 32'h4, 32'h0); set_host(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            end else begin
                set_core(1'b0, 1'b0, 32'h0, 32'h0); set_host(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
            end
            @(posedge clk); #1;
            $display("txn alternate %0d: core_vld=%b host_vld=%b data=%h", c, core_rd_vld, host_rd_vld, core_rd_data);
            if (c % 2 == 0) begin
                checks++; if (core_rd_vld !== 1'b1 || host_rd_vld !== 1'b0 || core_rd_data !== 32'hA000_0004) begin
                    errors++; $display("FAIL alt_core r%0d: got core_vld=%b host_vld=%b data=%h expected 1 0 a0000004", c, core_rd_vld, host_rd_vld, core_rd_data);
                end
            end else begin
                checks++; if (host_rd_vld !== 1'b1 || core_rd_vld !== 1'b0 || host_rd_data !== 32'hA000_0008) begin
                    errors++; $display("FAIL alt_host r%0d: got host_vld=%b core_vld=%b data=%h expected 1 0 a0000008", c, host_rd_vld, core_rd_vld, host_rd_data);
                end
            end
        end
        @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        set_host(1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
        @(posedge clk); #1;
        $display("txn async_reset: host locked read pending");
        checks++; if (host_rd_vld !== 1'b1) begin errors++; $display("FAIL arst_pre_vld: got %b expected 1", host_rd_vld); end
        #1 rst = 1'b1;
        #1;
        checks++; if (host_rd_vld !== 1'b0) begin errors++; $display("FAIL arst_host_vld: got %b expected 0", host_rd_vld); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || host_req_rdy !== 1'b0) begin
            errors++; $display("FAIL arst_mem: got re=%b we=%b host_rdy=%b expected 0 0 0", mem_re, mem_we, host_req_rdy);
        end
        // After release: IDLE with cleared starvation gives C,C,C,C,H.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            rst = 1'b0;
            set_core(1'b1, 1'b0, 32'h4, 32'h0);
            set_host(1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
            #1;
            $display("txn post_reset cycle %0d: core_rdy=%b host_rdy=%b", c, core_req_rdy, host_req_rdy);
            checks++; if (core_req_rdy !== (c != 4) || host_req_rdy !== (c == 4)) begin
                errors++; $display("FAIL arst_post c%0d: got core=%b host=%b expected core=%b host=%b", c, core_req_rdy, host_req_rdy, c != 4, c == 4);
            end
        end
        @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

`ifdef MEM_ARB_STATS_EN
    task automatic test_stats();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        set_core(1'b1, 1'b0, 32'h1, 32'h0);
        set_host(1'b1, 1'b0, 32'h2, 32'h0, 1'b0);
        repeat (10) @(negedge clk);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        set_core(1'b0, 1'b0, 32'h0, 32'h0);
        set_host(1'b1, 1'b0, 32'h2, 32'h0, 1'b0);
        @(negedge clk);
        set_host(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        $display("txn stats: core=%0d host=%0d forced=%0d", core_grant_cnt, host_grant_cnt, forced_grant_cnt);
        checks++; if (core_grant_cnt !== 32'd10) begin errors++; $display("FAIL stats_core: got %0d expected 10", core_grant_cnt); end
        checks++; if (host_grant_cnt !== 32'd3) begin errors++; $display("FAIL stats_host: got %0d expected 3", host_grant_cnt); end
        checks++; if (forced_grant_cnt !== 32'd2) begin errors++; $display("FAIL stats_forced: got %0d expected 2", forced_grant_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_core_read();
        test_starvation();
        test_host_lock();
        test_alternate();
        test_async_reset();
`ifdef MEM_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
